// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the fetch sequencer: machine word, instruction
// width, FSM state encoding and the branch offset scaling helper.
package fetch_sequencer_pkg;

    localparam int unsigned WORD        = 64;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef logic [WORD-1:0]        word_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_OUT  = 3'd2,
        S_NEXT = 3'd3,
        S_BR   = 3'd4
    } fetch_state_e;

    // Word offset scaled to bytes; the two top offset bits fall off the end.
    function automatic word_t scale_offset(input logic [WORD-3:0] off);
        return {off, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus: one outstanding request, response returned later.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic   req_valid;
    logic   req_ready;
    word_t  addr;
    logic   rsp_valid;
    instr_t rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem request at a time,
// hands instructions to decode and drives the shared external adder.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter word_t RESET_PC    = '0,
    parameter word_t INSTR_BYTES = word_t'(4)
) (
    input  logic                     clk,
    input  logic                     reset,

    output word_t                    adder_a,
    output word_t                    adder_b,
    input  word_t                    adder_sum,

    fetch_sequencer_if.master        imem,

    output logic                     instr_valid,
    input  logic                     instr_ready,
    output instr_t                   instr_out,
    output word_t                    instr_pc,

    input  logic                     branch_valid,
    input  word_t                    branch_base,
    input  word_t                    branch_offset,

    input  logic                     stall,
    output word_t                    pc
);

    fetch_state_e     state;
    logic             br_pend;
    word_t            br_base;
    logic [WORD-3:0]  br_off;
    logic             take_br;
    logic             unused_off_msbs;

    // A redirect is due if one is already pending or arrives this very cycle.
    assign take_br         = br_pend | branch_valid;
    assign unused_off_msbs = ^branch_offset[WORD-1:WORD-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            br_pend   <= 1'b0;
            br_base   <= '0;
            br_off    <= '0;
            instr_out <= '0;
            instr_pc  <= '0;
        end else begin
            if (branch_valid) begin
                br_pend <= 1'b1;
                br_base <= branch_base;
                br_off  <= branch_offset[WORD-3:0];
            end

            case (state)
                S_REQ: begin
                    if (imem.req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rsp_valid) begin
                        if (take_br) begin
                            state <= S_BR;
                        end else begin
                            instr_out <= imem.rsp_data;
                            instr_pc  <= pc;
                            state     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    // A branch squashes a waiting instruction; with the handshake it is consumed.
                    if (take_br)          state <= S_BR;
                    else if (instr_ready) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (take_br) begin
                        state <= S_BR;
                    end else if (!stall) begin
                        pc    <= adder_sum;
                        state <= S_REQ;
                    end
                end
                S_BR: begin
                    if (!stall) begin
                        pc      <= adder_sum;
                        // NOTE: this later non-blocking write overrides the set above, so a
                        // pulse landing in the completing cycle stays pending.
                        br_pend <= branch_valid;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Moore decode of the state; the reset term keeps everything quiet in the reset cycle.
    always_comb begin
        imem.req_valid = 1'b0;
        instr_valid    = 1'b0;
        adder_a        = '0;
        adder_b        = '0;
        if (!reset) begin
            case (state)
                S_REQ:  imem.req_valid = 1'b1;
                S_OUT:  instr_valid    = 1'b1;
                S_NEXT: begin
                    adder_a = pc;
                    adder_b = INSTR_BYTES;
                end
                S_BR: begin
                    adder_a = br_base;
                    adder_b = scale_offset(br_off);
                end
                default: ;
            endcase
        end
    end

    assign imem.addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level model of fetch addresses.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    word_t  adder_a, adder_b, adder_sum;
    logic   instr_valid, instr_ready;
    instr_t instr_out;
    word_t  instr_pc;
    logic   branch_valid;
    word_t  branch_base, branch_offset;
    logic   stall;
    word_t  pc;

    fetch_sequencer_if imem();

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: pending redirect target and next expected fetch.
    logic  m_pend;
    word_t m_tgt;
    word_t m_exp_addr;

    always #5 clk = ~clk;

    // The shared adder lives outside the block.
    assign adder_sum = adder_a + adder_b;

    fetch_sequencer #(
        .RESET_PC    (64'h0),
        .INSTR_BYTES (64'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_sum     (adder_sum),
        .imem          (imem.master),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .branch_valid  (branch_valid),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .stall         (stall),
        .pc            (pc)
    );

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; single-cycle pulse inputs drop after the edge.
    task automatic tick();
        @(negedge clk);
        branch_valid   = 1'b0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        instr_ready    = 1'b0;
    endtask

    task automatic pulse_branch(input word_t base, input word_t off);
        branch_valid  = 1'b1;
        branch_base   = base;
        branch_offset = off;
        m_pend        = 1'b1;
        m_tgt         = base + (off << 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        tick();
        tick();
        check("rst_req_valid", imem.req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_adder_a", adder_a, 0);
        check("rst_adder_b", adder_b, 0);
        check("rst_pc", pc, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_instr_pc", instr_pc, 0);
        reset = 1'b0;
        #1;
        m_pend     = 1'b0;
        m_exp_addr = '0;
    endtask

    task automatic wait_req(input string tag, input bit rand_stall);
        int n = 0;
        while (!imem.req_valid && n < 20) begin
            check({tag, "_no_instr"}, instr_valid, 0);
            stall = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
            n++;
        end
        stall = 1'b0;
        check({tag, "_req_seen"}, imem.req_valid, 1);
    endtask

    // Straight-line fetch: REQ, WAIT, OUT, NEXT, then back in REQ at addr+4.
    task automatic fetch_one(input word_t a, input instr_t d);
        check("seq_req_valid", imem.req_valid, 1);
        check("seq_addr", imem.addr, a);
        imem.req_ready = 1'b1;
        tick();
        check("seq_wait_no_req", imem.req_valid, 0);
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = d;
        tick();
        check("seq_instr_valid", instr_valid, 1);
        check("seq_instr_out", instr_out, d);
        check("seq_instr_pc", instr_pc, a);
        instr_ready = 1'b1;
        tick();
        check("seq_next_a", adder_a, a);
        check("seq_next_b", adder_b, 4);
        tick();
        check("seq_4cyc_req", imem.req_valid, 1);
        check("seq_pc_inc", pc, a + 4);
    endtask

    task automatic do_txn();
        word_t  cur;
        instr_t d;
        bit     discard, squashed;
        int     dly;

        wait_req("rnd", 1'b1);
        check("rnd_addr", imem.addr, m_exp_addr);
        cur = m_exp_addr;

        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            if ($urandom_range(0, 5) == 0) pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
            tick();
            check("rnd_req_hold", imem.req_valid, 1);
        end
        imem.req_ready = 1'b1;
        if ($urandom_range(0, 7) == 0) pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
        tick();

        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            if ($urandom_range(0, 7) == 0) pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
            tick();
            check("rnd_wait_idle", instr_valid, 0);
        end
        d = $urandom;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = d;
        if ($urandom_range(0, 7) == 0) pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
        discard = m_pend;
        tick();

        if (discard) begin
            check("rnd_discard", instr_valid, 0);
        end else begin
            check("rnd_valid", instr_valid, 1);
            check("rnd_data", instr_out, d);
            check("rnd_ipc", instr_pc, cur);
            squashed = 1'b0;
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly && !squashed; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
                    squashed = 1'b1;
                end
                tick();
                if (squashed) begin
                    check("rnd_squash", instr_valid, 0);
                end else begin
                    check("rnd_hold_valid", instr_valid, 1);
                    check("rnd_hold_data", instr_out, d);
                end
            end
            if (!squashed) begin
                instr_ready = 1'b1;
                if ($urandom_range(0, 7) == 0) pulse_branch({$urandom, $urandom}, {$urandom, $urandom});
                tick();
            end
        end

        m_exp_addr = m_pend ? m_tgt : cur + 4;
        m_pend     = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        branch_valid   = 1'b0;
        branch_base    = '0;
        branch_offset  = '0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        instr_ready    = 1'b0;

        // Sequential fetch from reset, four cycles each.
        do_reset();
        for (int k = 0; k < 3; k++) fetch_one(word_t'(k * 4), 32'hD503201F);

        // Decode back-pressure holds the instruction and blocks new requests.
        do_reset();
        imem.req_ready = 1'b1;
        tick();
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'hA1B2C3D4;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", instr_valid, 1);
            check("bp_data", instr_out, 32'hA1B2C3D4);
            check("bp_no_req", imem.req_valid, 0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        wait_req("bp", 1'b0);
        check("bp_next_addr", imem.addr, 64'h4);

        // Branch during WAIT discards the response.
        do_reset();
        imem.req_ready = 1'b1;
        tick();
        pulse_branch(64'h100, -64'sd2);
        tick();
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'h11111111;
        tick();
        check("bw_discard", instr_valid, 0);
        wait_req("bw", 1'b0);
        check("bw_addr", imem.addr, 64'hF8);

        // Newest of two pending branches wins.
        do_reset();
        pulse_branch(64'h40, 64'd8);
        tick();
        imem.req_ready = 1'b1;
        pulse_branch(64'h40, 64'd3);
        tick();
        imem.rsp_valid = 1'b1;
        tick();
        check("b2_discard", instr_valid, 0);
        wait_req("b2", 1'b0);
        check("b2_addr", imem.addr, 64'h4C);

        // Stall in NEXT at the top of the address space, then wrap to zero.
        do_reset();
        imem.req_ready = 1'b1;
        tick();
        pulse_branch(64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        imem.rsp_valid = 1'b1;
        tick();
        wait_req("wr", 1'b0);
        check("wr_addr", imem.addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem.req_ready = 1'b1;
        tick();
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'h5;
        tick();
        check("wr_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        instr_ready = 1'b1;
        stall       = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_pc_held", pc, 64'hFFFF_FFFF_FFFF_FFFC);
            check("wr_op_a", adder_a, 64'hFFFF_FFFF_FFFF_FFFC);
            check("wr_no_req", imem.req_valid, 0);
            if (i == 2) stall = 1'b0;
            tick();
        end
        check("wr_pc_wrap", pc, 64'h0);
        check("wr_req", imem.req_valid, 1);
        check("wr_next_addr", imem.addr, 64'h0);

        // Pulse in the cycle BR completes stays pending for the following pass.
        do_reset();
        imem.req_ready = 1'b1;
        tick();
        pulse_branch(64'h200, 64'd1);
        imem.rsp_valid = 1'b1;
        tick();
        check("bb_op_a", adder_a, 64'h200);
        check("bb_op_b", adder_b, 64'h4);
        pulse_branch(64'h300, 64'd0);
        tick();
        check("bb_first_addr", imem.addr, 64'h204);
        check("bb_first_req", imem.req_valid, 1);
        imem.req_ready = 1'b1;
        tick();
        imem.rsp_valid = 1'b1;
        tick();
        check("bb_discard", instr_valid, 0);
        wait_req("bb", 1'b0);
        check("bb_second_addr", imem.addr, 64'h300);

        // Reset in WAIT; a late response after reset is ignored.
        do_reset();
        fetch_one(64'h0, 32'hCAFEF00D);
        imem.req_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("rw_req_in_rst", imem.req_valid, 0);
        check("rw_pc", pc, 64'h0);
        reset = 1'b0;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'hDEADBEEF;
        tick();
        check("rw_late_ignored", instr_valid, 0);
        fetch_one(64'h0, 32'h12345678);

        // Randomized transactions against the model.
        do_reset();
        for (int t = 0; t < 250; t++) do_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
